// File: rtl/i2c_eeprom_slave_pkg.sv
// Shared definitions for the I2C serial-EEPROM slave: FSM encoding and bus constants.
package i2c_eeprom_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_WADDR,
    ST_WADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_MACK,
    ST_WRITE_CYC
  } state_e;

  // Level seen on SDA during the acknowledge bit.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [3:0] DEV_CODE_DEFAULT = 4'b1010;

  function automatic logic is_ack(input logic sda);
    return (sda == ACK) && (sda != NACK);
  endfunction

endpackage

// File: rtl/i2c_bus_detect.sv
// Oversampling front end: synchronises SCL/SDA and flags SCL edges and START/STOP.
module i2c_bus_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [1:0] pin_in;
  assign pin_in = {sda_i, scl_i};

  // Per line: bits [1:0] are the synchroniser, bit [2] the history stage.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic [2:0] pipe_q;
    always_ff @(posedge clk) begin
      if (!rst_n) pipe_q <= 3'b111;
      else        pipe_q <= {pipe_q[1:0], pin_in[gi]};
    end
  end

  logic scl_s, scl_h, sda_s, sda_h;
  assign scl_s = g_sync[0].pipe_q[1];
  assign scl_h = g_sync[0].pipe_q[2];
  assign sda_s = g_sync[1].pipe_q[1];
  assign sda_h = g_sync[1].pipe_q[2];

  assign scl_rise_o = scl_s & ~scl_h;
  assign scl_fall_o = ~scl_s & scl_h;
  assign start_o    = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_o     = scl_s & scl_h & ~sda_h & sda_s;
  assign sda_o      = sda_s;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 24Cxx-style I2C EEPROM slave with page buffer, timed write cycle and write protect.
module i2c_eeprom_slave
  import i2c_eeprom_slave_pkg::*;
#(
  parameter int         MEM_AW    = 11,
  parameter logic [3:0] DEV_CODE  = DEV_CODE_DEFAULT,
  parameter int         PAGE_SIZE = 16,
  parameter int         TWR_CYC   = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  input  logic wp,
  output logic busy
);

  localparam int PW = $clog2(PAGE_SIZE);
  localparam int CW = $clog2(TWR_CYC + 1);

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_bus_detect u_bus (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop),
    .sda_o     (sda_s)
  );

  state_e               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [MEM_AW-1:0]    ptr_q, ptr_d;
  logic [2:0]           blk_q, blk_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 mack_q, mack_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [PAGE_SIZE-1:0] valid_q, valid_d;
  logic                 buf_we;

  logic [7:0]           mem [2**MEM_AW];
  logic [7:0]           page_buf [PAGE_SIZE];
  logic [7:0]           rdata_q;

  logic                 byte_done, mem_we;
  logic [10:0]          word_addr;
  logic [MEM_AW-1:0]    mem_waddr;
  logic [PW-1:0]        slot;

  assign byte_done = (bit_cnt_q == 4'd8);
  assign word_addr = {blk_q, shift_q};
  assign slot      = ptr_q[PW-1:0];
  assign busy      = (state_q == ST_WRITE_CYC);
  assign sda_oe    = sda_oe_q;

  // The write cycle sweeps every page slot first, then idles out the remaining time.
  assign mem_we    = busy && (cyc_q < CW'(PAGE_SIZE)) && valid_q[cyc_q[PW-1:0]];
  assign mem_waddr = {ptr_q[MEM_AW-1:PW], cyc_q[PW-1:0]};

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= page_buf[cyc_q[PW-1:0]];
    rdata_q <= mem[ptr_q];
  end

  always_ff @(posedge clk) begin
    if (buf_we) page_buf[slot] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      blk_q     <= '0;
      sda_oe_q  <= 1'b0;
      mack_q    <= 1'b0;
      cyc_q     <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      blk_q     <= blk_d;
      sda_oe_q  <= sda_oe_d;
      mack_q    <= mack_d;
      cyc_q     <= cyc_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    blk_d     = blk_q;
    sda_oe_d  = sda_oe_q;
    mack_d    = mack_q;
    cyc_d     = cyc_q;
    valid_d   = valid_q;
    buf_we    = 1'b0;

    if (state_q == ST_WRITE_CYC) begin
      if (cyc_q == CW'(TWR_CYC - 1)) begin
        state_d = ST_IDLE;
        cyc_d   = '0;
        valid_d = '0;
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end else if (start) begin
      // A repeated START drops any uncommitted page data but keeps ptr.
      state_d   = ST_CTRL;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      valid_d   = '0;
    end else if (stop) begin
      state_d   = (|valid_q) ? ST_WRITE_CYC : ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      cyc_d     = '0;
    end else begin
      case (state_q)
        ST_CTRL, ST_WADDR, ST_WDATA: begin
          if (scl_rise && !byte_done) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && byte_done) begin
            bit_cnt_d = '0;
            if (state_q == ST_CTRL) begin
              if (shift_q[7:4] == DEV_CODE && !busy) begin
                blk_d    = shift_q[3:1];
                sda_oe_d = 1'b1;
                state_d  = ST_CTRL_ACK;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_IDLE;
              end
            end else if (state_q == ST_WADDR) begin
              sda_oe_d = 1'b1;
              state_d  = ST_WADDR_ACK;
            end else begin
              state_d = ST_WDATA_ACK;
              if (!wp) begin
                buf_we        = 1'b1;
                valid_d[slot] = 1'b1;
                ptr_d         = {ptr_q[MEM_AW-1:PW], slot + PW'(1)};
                sda_oe_d      = 1'b1;
              end
            end
          end
        end
        ST_CTRL_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (shift_q[0]) begin
              shift_d  = rdata_q;
              sda_oe_d = ~rdata_q[7];
              state_d  = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WADDR;
            end
          end
        end
        ST_WADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            ptr_d     = word_addr[MEM_AW-1:0];
            bit_cnt_d = '0;
            state_d   = ST_WDATA;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (scl_rise && !byte_done) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (byte_done) begin
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + MEM_AW'(1);
              bit_cnt_d = '0;
              state_d   = ST_RD_MACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_RD_MACK: begin
          if (scl_rise) begin
            mack_d = is_ack(sda_s);
          end else if (scl_fall) begin
            if (mack_q) begin
              shift_d  = rdata_q;
              sda_oe_d = ~rdata_q[7];
              state_d  = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench: bit-banged I2C master against the EEPROM slave with hand-computed expectations.
module tb_i2c_eeprom_slave;

  localparam int TWR = 1000;
  localparam int Q   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl   = 1'b1;
  logic sda_m = 1'b1;
  logic wp    = 1'b0;
  logic sda, sda_oe, busy;

  int n_vec    = 0;
  int n_err    = 0;
  int busy_cnt = 0;

  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];
  logic       ackv [10];

  assign sda = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  i2c_eeprom_slave #(
    .MEM_AW   (11),
    .DEV_CODE (4'b1010),
    .PAGE_SIZE(16),
    .TWR_CYC  (TWR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl_i (scl),
    .sda_i (sda),
    .sda_oe(sda_oe),
    .wp    (wp),
    .busy  (busy)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic s);
    wait_clk(Q); sda_m = b;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); s = sda;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      b[i] = s;
    end
    bit_io(~mack, s);
  endtask

  task automatic eeprom_write(input logic [7:0] ctrl, input logic [7:0] addr, input int n);
    logic k;
    i2c_start();
    send_byte(ctrl, k); ackv[0] = k;
    send_byte(addr, k); ackv[1] = k;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], k);
      ackv[2+i] = k;
    end
    i2c_stop();
  endtask

  task automatic eeprom_read(input logic [10:0] a, input int n);
    logic k;
    logic [7:0] ctl, b;
    ctl = {4'hA, a[10:8], 1'b0};
    i2c_start();
    send_byte(ctl, k);          check_vec("rd_ctrl_w_ack", k, 1);
    send_byte(a[7:0], k);       check_vec("rd_addr_ack", k, 1);
    i2c_start();
    send_byte(ctl | 8'h01, k);  check_vec("rd_ctrl_r_ack", k, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, b);
      rbuf[i] = b;
    end
    wait_clk(Q + 4);
    check_vec("rd_release", sda_oe, 0);
    i2c_stop();
  endtask

  task automatic wait_not_busy();
    int t;
    t = 0;
    wait_clk(2);
    while (busy && t < 3 * TWR) begin
      wait_clk(1);
      t++;
    end
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic k, s;
    logic [7:0] old_a, old_b, d77;
    int c0;

    // Reset state
    wait_clk(10);
    check_vec("rst_sda_oe", sda_oe, 0);
    check_vec("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_clk(10);

    // Single-byte write, busy length, random read back
    c0 = busy_cnt;
    wbuf[0] = 8'h5A;
    eeprom_write(8'hA0, 8'h12, 1);
    check_vec("t1_ctrl_ack", ackv[0], 1);
    check_vec("t1_addr_ack", ackv[1], 1);
    check_vec("t1_data_ack", ackv[2], 1);
    wait_not_busy();
    check_vec("t1_busy_len", busy_cnt - c0, TWR);
    eeprom_read(11'h012, 1);
    check_vec("t1_rd_012", rbuf[0], 8'h5A);

    // Page write wrapping inside the page, with ACK polling during the cycle
    eeprom_read(11'h110, 1);
    old_a = rbuf[0];
    wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
    c0 = busy_cnt;
    eeprom_write(8'hA2, 8'h0E, 4);
    check_vec("t2_ctrl_ack", ackv[0], 1);
    check_vec("t2_data4_ack", ackv[5], 1);
    wait_clk(10);
    check_vec("t3_busy", busy, 1);
    i2c_start();
    send_byte(8'hA0, k);
    check_vec("t3_poll_nack", k, 0);
    i2c_stop();
    wait_not_busy();
    check_vec("t2_busy_len", busy_cnt - c0, TWR);
    i2c_start();
    send_byte(8'hA0, k);
    check_vec("t3_poll_ack", k, 1);
    i2c_stop();
    eeprom_read(11'h10E, 3);
    check_vec("t2_rd_10e", rbuf[0], 8'h01);
    check_vec("t2_rd_10f", rbuf[1], 8'h02);
    check_vec("t2_rd_110", rbuf[2], old_a);
    eeprom_read(11'h100, 2);
    check_vec("t2_rd_100", rbuf[0], 8'h03);
    check_vec("t2_rd_101", rbuf[1], 8'h04);

    // Sequential read across the top of the array
    wbuf[0] = 8'hC1; wbuf[1] = 8'hC2;
    eeprom_write(8'hAE, 8'hFE, 2);
    wait_not_busy();
    wbuf[0] = 8'hD0; wbuf[1] = 8'hD1;
    eeprom_write(8'hA0, 8'h00, 2);
    wait_not_busy();
    eeprom_read(11'h7FE, 4);
    check_vec("t4_rd_7fe", rbuf[0], 8'hC1);
    check_vec("t4_rd_7ff", rbuf[1], 8'hC2);
    check_vec("t4_rd_000", rbuf[2], 8'hD0);
    check_vec("t4_rd_001", rbuf[3], 8'hD1);

    // Write protect
    eeprom_read(11'h020, 1);
    old_a = rbuf[0];
    wp = 1'b1;
    wbuf[0] = 8'hFF;
    c0 = busy_cnt;
    eeprom_write(8'hA0, 8'h20, 1);
    check_vec("t5_ctrl_ack", ackv[0], 1);
    check_vec("t5_addr_ack", ackv[1], 1);
    check_vec("t5_data_nack", ackv[2], 0);
    wait_clk(50);
    check_vec("t5_no_busy", busy_cnt - c0, 0);
    wp = 1'b0;
    eeprom_read(11'h020, 1);
    check_vec("t5_rd_020", rbuf[0], old_a);

    // Wrong device code, then a byte with no START must be ignored
    i2c_start();
    send_byte(8'hB0, k);
    check_vec("t6_b0_nack", k, 0);
    send_byte(8'hA0, k);
    check_vec("t6_idle_nack", k, 0);
    i2c_stop();

    // Reset while the slave is acknowledging a data byte
    eeprom_read(11'h030, 1);
    old_a = rbuf[0];
    c0 = busy_cnt;
    d77 = 8'h77;
    i2c_start();
    send_byte(8'hA0, k);
    send_byte(8'h30, k);
    for (int i = 7; i >= 0; i--) bit_io(d77[i], s);
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2);
    check_vec("t6_rst_pre_ack", sda_oe, 1);
    rst_n = 1'b0;
    wait_clk(1);
    check_vec("t6_rst_oe", sda_oe, 0);
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(Q); scl = 1'b0;
    i2c_stop();
    wait_clk(50);
    check_vec("t6_rst_no_commit", busy_cnt - c0, 0);
    eeprom_read(11'h030, 1);
    check_vec("t6_rd_030", rbuf[0], old_a);

    // Repeated START after two data bytes discards them
    eeprom_read(11'h040, 2);
    old_a = rbuf[0];
    old_b = rbuf[1];
    c0 = busy_cnt;
    i2c_start();
    send_byte(8'hA0, k);
    send_byte(8'h40, k);
    send_byte(8'h11, k);
    send_byte(8'h22, k);
    check_vec("t6_rs_data_ack", k, 1);
    i2c_start();
    i2c_stop();
    wait_clk(50);
    check_vec("t6_rs_no_commit", busy_cnt - c0, 0);
    eeprom_read(11'h040, 2);
    check_vec("t6_rd_040", rbuf[0], old_a);
    check_vec("t6_rd_041", rbuf[1], old_b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Synthesisable, parametrised I2C serial-EEPROM slave (24Cxx family) clocked by the system clock; SCL/SDA are oversampled rather than used as clocks.
- Adds page-buffered writes, a timed internal write cycle with ACK polling, write protect, and configurable memory depth and device code.
- Sits behind the board-level open-drain pad; used as the on-chip configuration store and as the bench target for the I2C master.

Parameters:
MEM_AW, 11, memory address width (8..11); depth = 2**MEM_AW bytes.
DEV_CODE, 4'b1010, control-byte bits [7:4] that select this device.
PAGE_SIZE, 16, page-write buffer depth in bytes (power of 2, 2..32).
TWR_CYC, 5000, internal write-cycle length in clk cycles (must be >= PAGE_SIZE).

Ports:
clk     input   1  system clock, >= 8x SCL frequency
rst_n   input   1  synchronous, active-low reset
scl_i   input   1  SCL pad input, asynchronous
sda_i   input   1  SDA pad input, asynchronous
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
wp      input   1  write protect, 1 = data bytes refused
busy    output  1  internal write cycle in progress

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Synchronisation: scl_i and sda_i each pass through a 2-FF synchroniser plus 1 history FF. All edge detection uses the synchronised values.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge, MSB first.
  - sda_oe changes only on the SCL falling edge, 1 clk after detection.
- Control byte: {DEV_CODE, blk[2:0], R/W}.
  - blk bits [MEM_AW-9:0] form the upper address bits. Unused blk bits are don't-care.
  - Address = {blk bits, word-address byte}.
- FSM states: IDLE, CTRL, CTRL_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WRITE_CYC.
  - START from any state except WRITE_CYC -> CTRL.
  - STOP outside WRITE_CYC -> IDLE.
  - CTRL: after 8 bits, ACK only if bits[7:4]==DEV_CODE and busy==0; otherwise release SDA and go IDLE.
  - W bit -> WADDR. R bit -> RDATA, loading mem[ptr].
  - WADDR_ACK: load ptr, then go to WDATA.
  - WDATA: each byte goes into page buffer slot ptr[log2(PAGE_SIZE)-1:0]. Slot valid bit is set and ptr low bits increment with wrap inside the page; upper ptr bits are unchanged.
  - More than PAGE_SIZE bytes overwrite earlier slots (last write wins).
  - wp==1: data bytes are NACKed, not buffered, and no write cycle follows.
  - RDATA: drive bits from the shift register. ptr increments mod 2**MEM_AW after each byte.
  - RD_MACK: master ACK -> next byte (mem[ptr]); master NACK -> IDLE (release SDA).
- Write commit:
  - STOP with at least one valid slot -> WRITE_CYC; busy=1 on the next clk.
  - Valid slots are written to mem one per clk, then a counter runs to TWR_CYC. At terminal count: busy=0, valid bits cleared, back to IDLE.
  - A repeated START before STOP discards buffered bytes (no commit); the word address is kept for random read.
- ACK polling: during WRITE_CYC, START/STOP are still tracked. Control bytes are NACKed (sda_oe stays 0).
- Address pointer after a write = last written address + 1 (page wrap). A current-address read uses ptr unchanged.
- Reset: state IDLE, sda_oe=0, busy=0, ptr=0, valid bits cleared, counters 0. Memory contents are preserved. Reset mid-write-cycle aborts uncommitted bytes.

Decomposition:
- Shared package/header: FSM state encodings, ACK/NACK constants, DEV_CODE default.
- One sub-module, i2c_bus_detect: synchronisers, SCL rise/fall, START/STOP pulses, synchronised SDA.
- Memory array and page buffer stay in the top level.

Test Plan:
1. Reset, then byte write: ctrl 0xA0, addr 0x12, data 0x5A, STOP -> ACK on all 3 bytes; busy=1 for TWR_CYC clks; random read of 0x012 returns 0x5A.
2. Page write wrap (PAGE_SIZE=16): ctrl 0xA2, addr 0x0E, data 0x01..0x04 -> stored at 0x10E, 0x10F, 0x100, 0x101; 0x110 unchanged.
3. ACK polling: ctrl 0xA0 issued during busy -> NACK. Same byte after busy falls -> ACK.
4. Sequential read from 0x7FE (MEM_AW=11): 4 bytes with master ACK,ACK,ACK,NACK -> bytes from 0x7FE, 0x7FF, 0x000, 0x001; SDA released after the NACK.
5. wp=1: ctrl 0xA0, addr 0x20, data 0xFF -> ctrl/addr ACK, data NACK; busy stays 0; mem[0x020] unchanged.
6. Abort cases:
   - ctrl 0xB0 -> NACK, FSM returns to IDLE.
   - rst_n low mid data byte -> sda_oe=0 on the next clk, no commit.
   - Repeated START after 2 data bytes -> nothing written.
